// File: rtl/greet_text_engine.sv
// greet_text_engine: multi-row, multi-character text sprite engine.
// During horizontal blanking it fetches the next line's code points from the
// greeting ROM and the matching glyph lines from the font ROM into a staging
// buffer. The staging buffer is copied to the display buffer at end of line,
// and scaled glyph pixels are emitted during the active part of the next line.
module greet_text_engine #(
  parameter int CORDW      = 10,
  parameter int H_RES      = 640,
  parameter int H_RES_FULL = 800,
  parameter int V_RES      = 480,
  parameter int V_RES_FULL = 525,
  parameter int CHARS      = 8,
  parameter int ROWS       = 2,
  parameter int MSGS       = 32,
  parameter int MSG_LEN    = 16,
  parameter int CP_W       = 7,
  parameter int CP_START   = 'h20,
  parameter int GLYPHS     = 64,
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 8,
  parameter int SCALE_X    = 8,
  parameter int SCALE_Y    = 8,
  parameter int X0         = 64,
  parameter int PITCH_X    = 64,
  parameter int Y0         = 150,
  parameter int PITCH_Y    = 100,
  parameter int MSG_CHG    = 80,
  parameter int LSB        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CORDW-1:0]                     sx,
  input  logic [CORDW-1:0]                     sy,
  input  logic                                 hold,
  input  logic                                 msg_next,
  output logic [$clog2(MSGS*MSG_LEN)-1:0]      greet_addr,
  input  logic [CP_W-1:0]                      greet_data,
  output logic [$clog2(GLYPHS*GLYPH_H)-1:0]    font_addr,
  input  logic [GLYPH_W-1:0]                   font_data,
  output logic [$clog2(MSGS)-1:0]              msg,
  output logic                                 busy,
  output logic                                 pix
);

  localparam int GA_W  = $clog2(MSGS*MSG_LEN);
  localparam int FA_W  = $clog2(GLYPHS*GLYPH_H);
  localparam int MSG_W = $clog2(MSGS);
  localparam int FC_W  = (MSG_CHG > 1) ? $clog2(MSG_CHG) : 1;
  localparam int KW    = $clog2(CHARS + 2);
  localparam int CIW   = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GLW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int GB_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int SX_SH = $clog2(SCALE_X);
  localparam int SY_SH = $clog2(SCALE_Y);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                         state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [FC_W-1:0]                fc_q;
  logic [GA_W-1:0]                base_q;
  logic [GLW-1:0]                 gl_q;
  logic                           cp_ok, cp_ok_q;
  logic [CHARS-1:0][GLYPH_W-1:0]  staging, display;
  logic                           disp_valid, fetch_done;

  logic                           line_start, line_end, frame_tick, fc_last, advance;
  int                             ny;
  logic                           row_hit;
  logic [RW-1:0]                  row_sel;
  logic [GLW-1:0]                 gl_sel;
  logic                           px_hit;
  logic [GB_W-1:0]                px_bit;

  assign line_start = (sx == CORDW'(H_RES));
  assign line_end   = (sx == CORDW'(H_RES_FULL - 1));
  assign frame_tick = line_start && (sy == CORDW'(V_RES)) && !hold;
  assign fc_last    = (fc_q == FC_W'(MSG_CHG - 1));
  // A rollover and a msg_next pulse in the same cycle merge into one step.
  assign advance    = (frame_tick && fc_last) || msg_next;

  // Frame counter and message selector.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q <= '0;
      msg  <= '0;
    end else begin
      if (frame_tick) fc_q <= fc_last ? '0 : fc_q + FC_W'(1);
      if (advance)    msg  <= (msg == MSG_W'(MSGS - 1)) ? '0 : msg + MSG_W'(1);
    end
  end

  // Decode which text row (if any) covers the next line, and its glyph line.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    ny      = (int'(sy) == V_RES_FULL - 1) ? 0 : int'(sy) + 1;
    row_hit = 1'b0;
    row_sel = '0;
    gl_sel  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (ny >= Y0 + r*PITCH_Y && ny < Y0 + r*PITCH_Y + GLYPH_H*SCALE_Y) begin
        row_hit = 1'b1;
        row_sel = RW'(r);
        gl_sel  = GLW'((ny - (Y0 + r*PITCH_Y)) >>> SY_SH);
      end
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Fetch FSM next state and ROM address outputs.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    greet_addr = '0;
    font_addr  = '0;
    busy       = (state_q == FETCH);
    cp_ok      = (int'(greet_data) >= CP_START) && (int'(greet_data) < CP_START + GLYPHS);
    case (state_q)
      IDLE: begin
        if (line_start && row_hit) begin
          state_d = FETCH;
          k_d     = '0;
        end
      end
      FETCH: begin
        if (k_q < KW'(CHARS)) greet_addr = base_q + GA_W'(k_q);
        if (k_q >= KW'(1) && k_q <= KW'(CHARS) && cp_ok)
          font_addr = FA_W'((int'(greet_data) - CP_START) * GLYPH_H + int'(gl_q));
        if (k_q == KW'(CHARS + 1)) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch datapath: latch line context, fill staging, swap buffers at end of line.
  // NOTE: the glyph buffers are cleared on reset so no stale text can appear
  // before the first complete fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      gl_q       <= '0;
      cp_ok_q    <= 1'b0;
      staging    <= '0;
      display    <= '0;
      disp_valid <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      if (state_q == IDLE && line_start && row_hit) begin
        // Message is sampled once here so a mid-line change waits for the next fetch.
        base_q <= GA_W'(int'(msg) * MSG_LEN + int'(row_sel) * CHARS);
        gl_q   <= gl_sel;
      end
      if (state_q == FETCH) begin
        cp_ok_q <= cp_ok;
        if (k_q >= KW'(2)) staging[CIW'(k_q - KW'(2))] <= cp_ok_q ? font_data : '0;
        if (k_q == KW'(CHARS + 1)) fetch_done <= 1'b1;
      end
      if (line_end) begin
        display    <= staging;
        disp_valid <= fetch_done;
        fetch_done <= 1'b0;
      end
    end
  end

  // Select the glyph bit under the current sx (at most one character matches).
  always_comb begin
    px_hit = 1'b0;
    px_bit = '0;
    for (int i = 0; i < CHARS; i++) begin
      if (int'(sx) >= X0 + i*PITCH_X && int'(sx) < X0 + i*PITCH_X + GLYPH_W*SCALE_X) begin
        px_bit = GB_W'((int'(sx) - (X0 + i*PITCH_X)) >>> SX_SH);
        if (LSB == 0) px_bit = GB_W'(GLYPH_W - 1) - px_bit;
        px_hit = display[i][px_bit];
      end
    end
  end

  // Registered pixel output, one cycle behind sx/sy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix <= 1'b0;
    else     pix <= disp_valid && (int'(sx) < H_RES) && (int'(sy) < V_RES) && px_hit;
  end

endmodule

// File: doc/greet_text_engine.md
Name: greet_text_engine

Overview:
- Parametrised multi-row, multi-character text-sprite engine. Replaces hand-instanced per-letter sprites, DMA slot decoding and the greeting selector with one block.
- During each horizontal blanking interval it fetches the code points for the next line's text row from the greeting ROM, then the matching glyph lines from the font ROM. Data is double-buffered; scaled glyph pixels are emitted during the active line.
- Sits between display_timings and the colour/DVI output stage. The greeting and font ROMs (1-cycle-latency bram) are external.

Parameters:
- CORDW, 10, screen coordinate width in bits
- H_RES, 640, active width
- H_RES_FULL, 800, total line width
- V_RES, 480, active height
- V_RES_FULL, 525, total frame height
- CHARS, 8, characters per text row; CHARS+2 <= H_RES_FULL-H_RES
- ROWS, 2, text rows drawn; ROWS*CHARS <= MSG_LEN
- MSGS, 32, messages in greeting ROM
- MSG_LEN, 16, code points per message
- CP_W, 7, code point width
- CP_START, 'h20, first code point in font
- GLYPHS, 64, glyphs in font ROM
- GLYPH_W, 8, glyph width in pixels (font ROM data width)
- GLYPH_H, 8, glyph height in lines
- SCALE_X, 8, horizontal magnification (power of two)
- SCALE_Y, 8, vertical magnification (power of two)
- X0, 64, left edge of character 0
- PITCH_X, 64, horizontal distance between characters; must be >= GLYPH_W*SCALE_X
- Y0, 150, top of row 0
- PITCH_Y, 100, vertical distance between rows; must be >= GLYPH_H*SCALE_Y
- MSG_CHG, 80, frames per message
- LSB, 0, 1 = glyph bit 0 is leftmost pixel; 0 = MSB leftmost

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active high
- sx  in  CORDW  horizontal screen position
- sy  in  CORDW  vertical screen position
- hold  in  1  freezes frame counter (message does not auto-advance)
- msg_next  in  1  single-cycle pulse: advance to next message
- greet_addr  out  clog2(MSGS*MSG_LEN)  greeting ROM address
- greet_data  in  CP_W  greeting ROM data, valid 1 cycle after address
- font_addr  out  clog2(GLYPHS*GLYPH_H)  font ROM address
- font_data  in  GLYPH_W  font ROM data, valid 1 cycle after address
- msg  out  clog2(MSGS)  current message index
- busy  out  1  high while the fetch FSM is not IDLE
- pix  out  1  text pixel, 1 cycle after sx/sy

Behaviour:
- Reset (async, active high):
  - Outputs: msg=0, pix=0, busy=0, greet_addr=0, font_addr=0.
  - Internal: frame counter 0; FSM IDLE; staging and display buffers all zero; display-valid cleared.
- Message selector:
  - At sx==H_RES && sy==V_RES, if !hold: frame counter increments. On reaching MSG_CHG-1 it wraps to 0 and msg increments, giving a period of exactly MSG_CHG frames.
  - msg_next advances msg on the cycle after the pulse.
  - msg_next coincident with a rollover advances msg by one only.
  - msg wraps MSGS-1 -> 0.
  - A change to msg mid-line takes effect at the next fetch.
- Next-line decode at sx==H_RES:
  - ny = (sy==V_RES_FULL-1) ? 0 : sy+1.
  - Row r is active when Y0+r*PITCH_Y <= ny < Y0+r*PITCH_Y+GLYPH_H*SCALE_Y.
  - gl = (ny - row top) >> log2(SCALE_Y).
  - If no row is active, FSM stays IDLE and the display buffer is marked invalid at end of line.
- Fetch FSM: IDLE -> FETCH -> IDLE.
  - Enter FETCH at sx==H_RES when a row is active; remain for CHARS+2 cycles. k counts cycles 0..CHARS+1.
  - k < CHARS: greet_addr = msg*MSG_LEN + r*CHARS + k.
  - 1 <= k <= CHARS: capture cp = greet_data for char k-1 and drive font_addr = (cp-CP_START)*GLYPH_H + gl.
  - 2 <= k <= CHARS+1: staging[k-2] <= font_data.
  - cp < CP_START or cp >= CP_START+GLYPHS: font_addr is don't-care and staging for that char is forced to 0 (blank).
  - Outside FETCH both addresses are 0.
- Buffer swap at sx==H_RES_FULL-1:
  - display <= staging.
  - display-valid <= (a fetch completed this line).
- Pixel output:
  - Character i spans X0+i*PITCH_X <= sx < X0+i*PITCH_X+GLYPH_W*SCALE_X.
  - Bit b = (sx - left) >> log2(SCALE_X), reversed when LSB=0.
  - pix <= display-valid && sx<H_RES && sy<V_RES && display[i][b]; registered, 1-cycle latency.
  - At most one character is active per sx (pitch constraint).
- Reset mid-fetch or mid-line: everything clears immediately; no text appears until the first full fetch after reset is released.

Test Plan:
- Message 0 row 0 = "HI", font 'H' line 0 = 8'b01100110, LSB=0, sy=149 at sx=640 -> greet_addr 0,1,...,7 on consecutive cycles; font_addr = ('H'-'h20)*8+0 = 320 on cycle k=1. On line 150, pix=1 for sx in 72..87 (asserted at sx+1), pix=0 for sx in 64..71.
- ny=158 (row 0 top 150, SCALE_Y=8) -> gl=1; ny=250 -> r=1, greet_addr starts at MSG_LEN*msg+8; ny=214 -> no fetch, busy stays 0, pix=0 all line.
- Code point 'h7F in message -> that character draws blank; neighbouring characters are unaffected.
- hold=0, MSG_CHG=3 -> msg increments every 3rd sx==640/sy==480 event; msg 31 wraps to 0. hold=1 -> msg is constant over 10 frames.
- msg_next pulse on the same cycle as a rollover -> msg advances by exactly 1.
- rst asserted at k=4 of a fetch -> pix, busy, msg and addresses are 0 asynchronously. After release, no pix until a complete fetch and swap occur.
